// File: rtl/dsync_hs_tx.sv
// Source-side controller for a 4-phase req/ack handshake carrying one DW-bit word
// into another clock domain, with an optional REQ/DROP timeout and a sticky error flag.
module dsync_hs_tx #(
    parameter int DW      = 32,
    parameter int PS      = 2,
    parameter int TIMEOUT = 0
) (
    input  logic          clk,
    input  logic          nreset,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          in_ready,
    output logic          tx_req,
    output logic [DW-1:0] tx_data,
    input  logic          tx_ack,
    output logic          busy,
    output logic          done,
    output logic          err,
    input  logic          err_clr
);

    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DROP = 2'd2
    } state_t;

    state_t          state;
    logic [PS-1:0]   ack_sync;
    logic            ack_s;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   cnt_inc;
    logic            tmo_hit;
    logic            err_q;

    assign ack_s    = ack_sync[PS-1];
    assign in_ready = (state == IDLE) && !ack_s;
    assign busy     = (state != IDLE);

    // With TIMEOUT=0 the counter is held at zero and the abort path is constant-false.
    assign cnt_inc  = (TIMEOUT > 0) ? cnt + CW'(1) : '0;
    assign tmo_hit  = (TIMEOUT > 0) && (cnt == CW'(TIMEOUT - 1));
    assign err      = (TIMEOUT > 0) ? err_q : 1'b0;

    // ack synchronizer stage boundary: tx_ack is asynchronous to clk
    always_ff @(posedge clk) begin
        if (!nreset) begin
            ack_sync <= '0;
        end else begin
            ack_sync <= {ack_sync[PS-2:0], tx_ack};
        end
    end

    // handshake FSM stage boundary: all outputs registered here
    always_ff @(posedge clk) begin
        if (!nreset) begin
            state   <= IDLE;
            tx_req  <= 1'b0;
            tx_data <= '0;
            done    <= 1'b0;
            err_q   <= 1'b0;
            cnt     <= '0;
        end else begin
            done <= 1'b0;
            if (err_clr) begin
                err_q <= 1'b0;
            end
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (in_valid && in_ready) begin
                        state   <= REQ;
                        tx_data <= in_data;
                        tx_req  <= 1'b1;
                    end
                end
                REQ: begin
                    if (ack_s) begin
                        state  <= DROP;
                        tx_req <= 1'b0;
                        cnt    <= '0;
                    end else if (tmo_hit) begin
                        // abort; a late ack is fenced off by in_ready while ack_s is high
                        state  <= IDLE;
                        tx_req <= 1'b0;
                        err_q  <= 1'b1;
                        cnt    <= '0;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                DROP: begin
                    if (!ack_s) begin
                        state <= IDLE;
                        done  <= 1'b1;
                        cnt   <= '0;
                    end else if (tmo_hit) begin
                        state <= IDLE;
                        err_q <= 1'b1;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                default: begin
                    state  <= IDLE;
                    tx_req <= 1'b0;
                    cnt    <= '0;
                end
            endcase
        end
    end

endmodule
